// File: rtl/bcd_pkg.sv
// Types and constants shared by the BCD<->binary conversion blocks.
// The state encoding and the digit limit are common to both conversion directions.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic logic is_bad_digit(input logic [3:0] d);
    return d > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One multiply-accumulate step of BCD-to-binary conversion: acc*10 + digit.
// Also flags a non-decimal digit and a result that no longer fits in WIDTH bits.
module bcd_mac_step
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+3:0] acc,
  input  logic [3:0]       digit,
  output logic [WIDTH+3:0] acc_next,
  output logic             digit_bad,
  output logic             step_ovf
);

  // acc never exceeds 2^WIDTH-1, so the shifted terms and the sum stay inside WIDTH+4 bits.
  assign acc_next  = (acc << 3) + (acc << 1) + {{WIDTH{1'b0}}, digit};
  assign digit_bad = is_bad_digit(digit);
  assign step_ovf  = |acc_next[WIDTH+3:WIDTH];

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, most significant digit first,
// with saturating overflow and invalid-digit reporting held alongside the result.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW = WIDTH + 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  state_t              state_reg, state_next;
  logic [4*DIGITS-1:0] shift_reg, shift_next;
  logic [AW-1:0]       acc_reg, acc_step;
  logic [CW-1:0]       cnt_reg;
  logic                err_sticky_reg, ovf_sticky_reg;
  logic [WIDTH-1:0]    bin_reg;
  logic                err_reg, ovf_reg;
  logic                accept, last_digit, digit_bad, step_ovf;
  logic [3:0]          digit;

  assign digit      = shift_reg[4*DIGITS-1 -: 4];
  assign last_digit = (cnt_reg == '0);

  // Nibble-wise left shift: each digit slot takes its lower neighbour, slot 0 fills with zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_shift
      if (gi == 0) begin : g_low
        assign shift_next[3:0] = 4'h0;
      end else begin : g_up
        assign shift_next[gi*4 +: 4] = shift_reg[(gi-1)*4 +: 4];
      end
    end
  endgenerate

  bcd_mac_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_reg),
    .digit     (digit),
    .acc_next  (acc_step),
    .digit_bad (digit_bad),
    .step_ovf  (step_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg      <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      err_sticky_reg <= 1'b0;
      ovf_sticky_reg <= 1'b0;
      bin_reg        <= '0;
      err_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
    end else if (accept) begin
      shift_reg      <= bcd;
      acc_reg        <= '0;
      cnt_reg        <= CNT_LAST;
      err_sticky_reg <= 1'b0;
      ovf_sticky_reg <= 1'b0;
    end else if (state_reg == CONV) begin
      shift_reg <= shift_next;
      if (digit_bad) err_sticky_reg <= 1'b1;
      // On overflow acc is frozen; the sticky flag alone decides the final result.
      if (step_ovf) ovf_sticky_reg <= 1'b1;
      else          acc_reg        <= acc_step;
      if (!last_digit) cnt_reg <= cnt_reg - 1'b1;
      if (last_digit) begin
        if (err_sticky_reg || digit_bad) begin
          bin_reg <= '0;
          err_reg <= 1'b1;
          ovf_reg <= 1'b0;
        end else if (ovf_sticky_reg || step_ovf) begin
          bin_reg <= '1;
          err_reg <= 1'b0;
          ovf_reg <= 1'b1;
        end else begin
          bin_reg <= acc_step[WIDTH-1:0];
          err_reg <= 1'b0;
          ovf_reg <= 1'b0;
        end
      end
    end
  end

  assign bin = bin_reg;
  assign err = err_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed-vector bench for bcd2bin_seq: table of conversions, sequencing corner cases,
// reset abort and a full 0..255 round trip through a reference binary-to-BCD model.
module tb_bcd2bin_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [11:0]      bcd = 12'h000;
  logic [WIDTH-1:0] bin;
  logic             busy, done, err, ovf;

  int checks = 0;
  int failures = 0;

  bcd2bin_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [7:0]  bin;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Called at the first negedge after the accept edge; returns cycles until done and busy count.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_conv(input logic [11:0] v, output int lat, output int busy_cycles);
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_cycles);
  endtask

  initial begin
    int lat, bc;

    vecs[0]  = '{12'h255, 8'd255, 1'b0, 1'b0};
    vecs[1]  = '{12'h256, 8'hFF,  1'b0, 1'b1};
    vecs[2]  = '{12'h999, 8'hFF,  1'b0, 1'b1};
    vecs[3]  = '{12'h1A3, 8'h00,  1'b1, 1'b0};
    vecs[4]  = '{12'hF99, 8'h00,  1'b1, 1'b0};
    vecs[5]  = '{12'h000, 8'd0,   1'b0, 1'b0};
    vecs[6]  = '{12'h042, 8'd42,  1'b0, 1'b0};
    vecs[7]  = '{12'h100, 8'd100, 1'b0, 1'b0};
    vecs[8]  = '{12'h009, 8'd9,   1'b0, 1'b0};
    vecs[9]  = '{12'h250, 8'd250, 1'b0, 1'b0};
    vecs[10] = '{12'h0A0, 8'h00,  1'b1, 1'b0};
    vecs[11] = '{12'h260, 8'hFF,  1'b0, 1'b1};
    vecs[12] = '{12'h300, 8'hFF,  1'b0, 1'b1};
    vecs[13] = '{12'h128, 8'd128, 1'b0, 1'b0};

    // Reset held low: start must have no effect.
    bcd   = 12'h255;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_outputs", {bin, busy, done, err, ovf}, 32'h0);
    end
    $display("reset: bin=%0d busy=%0b done=%0b err=%0b ovf=%0b", bin, busy, done, err, ovf);
    start = 1'b0;
    rst   = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_conv(vecs[i].bcd, lat, bc);
      check("latency", lat, 32'd3);
      check("busy_cycles", bc, 32'd3);
      check("bin", bin, {24'h0, vecs[i].bin});
      check("err", err, {31'h0, vecs[i].err});
      check("ovf", ovf, {31'h0, vecs[i].ovf});
      $display("vec bcd=%03h bin=%0d err=%0b ovf=%0b lat=%0d", vecs[i].bcd, bin, err, ovf, lat);
      @(negedge clk);
      check("done_one_cycle", done, 32'd0);
    end

    // Start held while in DONE restarts immediately; old result held during the new CONV.
    run_conv(12'h000, lat, bc);
    check("seq0_bin", bin, 32'd0);
    bcd   = 12'h042;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", busy, 32'd1);
    check("restart_done_low", done, 32'd0);
    check("held_bin", bin, 32'd0);
    wait_done(lat, bc);
    check("restart_latency", lat, 32'd3);
    check("seq1_bin", bin, 32'd42);
    $display("seq restart: bin=%0d lat=%0d", bin, lat);

    // Mid-CONV start ignored, bcd changed after accept, err held during the next CONV.
    run_conv(12'h1A3, lat, bc);
    check("pre_err", err, 32'd1);
    @(negedge clk);
    bcd   = 12'h123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd   = 12'h999;
    @(negedge clk);
    check("held_err", err, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd   = 12'h777;
    wait_done(lat, bc);
    check("ignore_latency", lat, 32'd1);
    check("ignore_bin", bin, 32'd123);
    check("ignore_err", err, 32'd0);
    check("ignore_ovf", ovf, 32'd0);
    @(negedge clk);
    check("no_queue_busy", busy, 32'd0);
    check("no_queue_done", done, 32'd0);
    $display("seq ignore: bin=%0d err=%0b", bin, err);

    // Reset on the 2nd CONV cycle aborts the conversion.
    @(negedge clk);
    bcd   = 12'h255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 32'd0);
    check("abort_done", done, 32'd0);
    check("abort_bin", bin, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", {busy, done}, 32'd0);
    end
    $display("abort: busy=%0b done=%0b bin=%0d", busy, done, bin);

    // Round trip every 8-bit value through the reference binary-to-BCD model.
    for (int v = 0; v < 256; v++) begin
      run_conv(to_bcd(v), lat, bc);
      check("sweep", {err, ovf, bin}, v);
      check("sweep_latency", lat, 32'd3);
      $display("sweep v=%0d bcd=%03h bin=%0d", v, to_bcd(v), bin);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
